// File: rtl/audio_pkg.sv
// Shared defaults and FSM state encoding for the audio min/max scan engine.
package audio_pkg;
  localparam int N_SAMPLES_DEF = 100;
  localparam int SAMPLE_W_DEF  = 32;
  localparam int ADDR_W_DEF    = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/audio_minmax_sched_accum.sv
// Running signed min/max over a stream of samples; a flagged first sample seeds both.
module minmax_accum
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] cur_max,
  output logic [SAMPLE_W-1:0] cur_min
);
  logic signed [SAMPLE_W-1:0] max_q, max_d, min_q, min_d;
  logic signed [SAMPLE_W-1:0] s;

  assign s = sample;

  // Strict compares: a tie keeps the value already held.
  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (valid) begin
      if (clear) begin
        max_d = s;
        min_d = s;
      end else begin
        if (s > max_q) max_d = s;
        if (s < min_q) min_d = s;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign cur_max = max_q;
  assign cur_min = min_q;
endmodule

// File: rtl/audio_minmax_sched.sv
// Two-requester round-robin scheduler sharing one frame min/max scan engine.
module audio_minmax_sched
  import audio_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  output logic                rd_en,
  output logic                rd_sel,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic [1:0]          grant,
  output logic                busy,
  output logic [1:0]          done,
  output logic                res_sel,
  output logic [SAMPLE_W-1:0] out_max,
  output logic [SAMPLE_W-1:0] out_min
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                sel_q, sel_d;
  logic                ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                vld_q, first_q;
  logic                res_sel_q;
  logic [SAMPLE_W-1:0] out_max_q, out_min_q;
  logic [SAMPLE_W-1:0] cur_max, cur_min;
  logic                win;

  // ptr_q names the requester favoured on a tie.
  assign win = req[1] & (~req[0] | ptr_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: if (|req) begin
        state_d = ST_READ;
        sel_d   = win;
        grant_d = win ? 2'b10 : 2'b01;
        addr_d  = '0;
      end
      ST_READ: if (addr_q == LAST) state_d = ST_DRAIN;
               else addr_d = addr_q + 1'b1;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        ptr_d   = ~sel_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      sel_q     <= 1'b0;
      ptr_q     <= 1'b0;
      addr_q    <= '0;
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      res_sel_q <= 1'b0;
      out_max_q <= '0;
      out_min_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      // Sample returns one cycle after the strobe; track which one is address 0.
      vld_q   <= rd_en;
      first_q <= rd_en && (addr_q == '0);
      if (state_q == ST_DONE) begin
        res_sel_q <= sel_q;
        out_max_q <= cur_max;
        out_min_q <= cur_min;
      end
    end
  end

  minmax_accum #(.SAMPLE_W(SAMPLE_W)) u_accum (
    .clk     (clk),
    .reset   (reset),
    .clear   (first_q),
    .valid   (vld_q),
    .sample  (rd_data),
    .cur_max (cur_max),
    .cur_min (cur_min)
  );

  assign rd_en   = (state_q == ST_READ);
  assign rd_sel  = sel_q;
  assign rd_addr = addr_q;
  assign grant   = grant_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign res_sel = res_sel_q;
  assign out_max = out_max_q;
  assign out_min = out_min_q;
endmodule

// File: tb/tb_audio_minmax_sched.sv
// Directed-vector bench for audio_minmax_sched with a one-cycle-latency buffer model.
module tb_audio_minmax_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic        rd_en, rd_sel, busy, res_sel;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic [1:0]  grant, done;
  logic [31:0] out_max, out_min;

  logic [31:0] buf0 [0:99];
  logic [31:0] buf1 [0:99];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  audio_minmax_sched dut (
    .clk(clk), .reset(reset), .req(req), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_addr(rd_addr), .rd_data(rd_data), .grant(grant), .busy(busy),
    .done(done), .res_sel(res_sel), .out_max(out_max), .out_min(out_min)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= rd_sel ? buf1[rd_addr] : buf0[rd_addr];

  // Speech-like frame: values -27..7 in units of 65536.
  task load_speech();
    for (int i = 0; i < 100; i++) buf0[i] = 32'(((i * 37) % 35) - 27) * 32'h10000;
  endtask

  task load_minus5();
    for (int i = 0; i < 100; i++) buf1[i] = 32'hFFFF_FFFB;
  endtask

  task wait_done(output logic [1:0] d, output int at, output int nrd, output logic [1:0] g);
    d = 2'b00; at = -1; nrd = 0; g = 2'b00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rd_en) nrd++;
      if (busy && g == 2'b00) g = grant;
      if (done != 2'b00) begin
        d = done; at = cyc;
        break;
      end
    end
  endtask

  task test_reset();
    reset = 1'b0; req = 2'b00;
    repeat (3) @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant got %b exp 00", grant); end
    vectors++; if (done !== 2'b00) begin miscompares++; $display("FAIL rst_done got %b exp 00", done); end
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en got %b exp 0", rd_en); end
    vectors++; if (rd_addr !== 7'd0) begin miscompares++; $display("FAIL rst_rd_addr got %0d exp 0", rd_addr); end
    vectors++; if (rd_sel !== 1'b0) begin miscompares++; $display("FAIL rst_rd_sel got %b exp 0", rd_sel); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
    vectors++; if (res_sel !== 1'b0) begin miscompares++; $display("FAIL rst_res_sel got %b exp 0", res_sel); end
    vectors++; if (out_max !== 32'h0) begin miscompares++; $display("FAIL rst_out_max got %h exp 0", out_max); end
    vectors++; if (out_min !== 32'h0) begin miscompares++; $display("FAIL rst_out_min got %h exp 0", out_min); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task test_single();
    logic [1:0] d, g; int at, nrd, t0;
    t0 = cyc; req = 2'b01;
    wait_done(d, at, nrd, g);
    req = 2'b00;
    vectors++; if (d !== 2'b01) begin miscompares++; $display("FAIL single_done got %b exp 01", d); end
    vectors++; if (at - t0 != 102) begin miscompares++; $display("FAIL single_latency got %0d exp 102", at - t0); end
    vectors++; if (nrd != 100) begin miscompares++; $display("FAIL single_reads got %0d exp 100", nrd); end
    vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL single_grant got %b exp 01", g); end
    @(negedge clk);
    vectors++; if (out_max !== 32'h0007_0000) begin miscompares++; $display("FAIL single_max got %0d exp 458752", $signed(out_max)); end
    vectors++; if (out_min !== 32'hFFE5_0000) begin miscompares++; $display("FAIL single_min got %0d exp -1769472", $signed(out_min)); end
    vectors++; if (res_sel !== 1'b0) begin miscompares++; $display("FAIL single_res_sel got %b exp 0", res_sel); end
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL single_idle_grant got %b exp 00", grant); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy got %b exp 0", busy); end
  endtask

  task test_simultaneous();
    logic [1:0] d, g; int at, nrd;
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    req = 2'b11;
    wait_done(d, at, nrd, g);
    vectors++; if (d !== 2'b01) begin miscompares++; $display("FAIL sim_first_done got %b exp 01", d); end
    vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL sim_first_grant got %b exp 01", g); end
    req = 2'b10;
    @(negedge clk);
    vectors++; if (out_max !== 32'h0007_0000) begin miscompares++; $display("FAIL sim_first_max got %0d exp 458752", $signed(out_max)); end
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL sim_idle_grant got %b exp 00", grant); end
    wait_done(d, at, nrd, g);
    req = 2'b00;
    vectors++; if (d !== 2'b10) begin miscompares++; $display("FAIL sim_second_done got %b exp 10", d); end
    vectors++; if (g !== 2'b10) begin miscompares++; $display("FAIL sim_second_grant got %b exp 10", g); end
    @(negedge clk);
    vectors++; if (out_max !== 32'hFFFF_FFFB) begin miscompares++; $display("FAIL sim_max got %0d exp -5", $signed(out_max)); end
    vectors++; if (out_min !== 32'hFFFF_FFFB) begin miscompares++; $display("FAIL sim_min got %0d exp -5", $signed(out_min)); end
    vectors++; if (res_sel !== 1'b1) begin miscompares++; $display("FAIL sim_res_sel got %b exp 1", res_sel); end
  endtask

  task test_extremes();
    logic [1:0] d, g; int at, nrd;
    for (int i = 0; i < 100; i++) buf0[i] = 32'h0;
    buf0[0] = 32'h7FFF_FFFF; buf0[99] = 32'h8000_0000;
    req = 2'b01;
    wait_done(d, at, nrd, g);
    req = 2'b00;
    vectors++; if (d !== 2'b01) begin miscompares++; $display("FAIL ext_done got %b exp 01", d); end
    @(negedge clk);
    vectors++; if (out_max !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL ext_max got %0d exp 2147483647", $signed(out_max)); end
    vectors++; if (out_min !== 32'h8000_0000) begin miscompares++; $display("FAIL ext_min got %0d exp -2147483648", $signed(out_min)); end
    vectors++; if (res_sel !== 1'b0) begin miscompares++; $display("FAIL ext_res_sel got %b exp 0", res_sel); end
  endtask

  task test_reset_abort();
    logic [1:0] d, g; int at, nrd, t0; bit found; bit saw_done;
    found = 0; saw_done = 0;
    req = 2'b01;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 7'd50) begin found = 1; break; end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL abort_reach_addr50 got 0 exp 1"); end
    reset = 1'b0; req = 2'b00;
    #1;
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL abort_grant got %b exp 00", grant); end
    vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("FAIL abort_rd_en got %b exp 0", rd_en); end
    vectors++; if (rd_addr !== 7'd0) begin miscompares++; $display("FAIL abort_rd_addr got %0d exp 0", rd_addr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b exp 0", busy); end
    vectors++; if (out_max !== 32'h0) begin miscompares++; $display("FAIL abort_out_max got %h exp 0", out_max); end
    vectors++; if (out_min !== 32'h0) begin miscompares++; $display("FAIL abort_out_min got %h exp 0", out_min); end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done != 2'b00 || busy) saw_done = 1;
    end
    vectors++; if (saw_done) begin miscompares++; $display("FAIL abort_quiet got activity exp none"); end
    t0 = cyc; req = 2'b01;
    wait_done(d, at, nrd, g);
    req = 2'b00;
    vectors++; if (d !== 2'b01) begin miscompares++; $display("FAIL abort_redo_done got %b exp 01", d); end
    vectors++; if (at - t0 != 102) begin miscompares++; $display("FAIL abort_redo_latency got %0d exp 102", at - t0); end
    @(negedge clk);
    vectors++; if (out_max !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL abort_redo_max got %0d exp 2147483647", $signed(out_max)); end
  endtask

  task test_fairness();
    logic [1:0] d, g; int at, nrd;
    load_speech();
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    req = 2'b01;
    repeat (20) @(negedge clk);
    req = 2'b11;
    wait_done(d, at, nrd, g);
    vectors++; if (d !== 2'b01) begin miscompares++; $display("FAIL fair_f0_done got %b exp 01", d); end
    vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL fair_f0_grant got %b exp 01", g); end
    wait_done(d, at, nrd, g);
    req = 2'b01;
    vectors++; if (d !== 2'b10) begin miscompares++; $display("FAIL fair_f1_done got %b exp 10", d); end
    vectors++; if (g !== 2'b10) begin miscompares++; $display("FAIL fair_f1_grant got %b exp 10", g); end
    wait_done(d, at, nrd, g);
    req = 2'b00;
    vectors++; if (d !== 2'b01) begin miscompares++; $display("FAIL fair_f2_done got %b exp 01", d); end
    vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL fair_f2_grant got %b exp 01", g); end
    @(negedge clk);
    vectors++; if (out_min !== 32'hFFE5_0000) begin miscompares++; $display("FAIL fair_f2_min got %0d exp -1769472", $signed(out_min)); end
  endtask

  initial begin
    load_speech();
    load_minus5();
    test_reset();
    test_single();
    test_simultaneous();
    test_extremes();
    test_reset_abort();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
